cp_tx_arb: RTL and testbench
============================

Name: cp_tx_arb

Overview:
- Shares the single serial transmitter between several byte-stream sources: control-panel status reply, command echo, debug dump.
- Each source sees a private send/busy handshake identical to the transmitter's own, so existing senders connect unchanged.
- Multi-byte frames are kept atomic by locking the grant until the source flags the last byte.
- Round-robin fairness is applied at frame boundaries.

Parameters:
- N, 3, number of requesters (2..8).
- LOCK_TIMEOUT, 1023, cycles a locked owner may stay silent before the lock is forcibly released.

Ports:
- clk_sys  in  1  system clock
- rst_n  in  1  synchronous active-low reset, sampled on clk_sys
- req_send  in  N  per-requester send strobe, held high until its req_busy rises
- req_byte  in  8*N  per-requester byte; requester i uses bits [8i+7:8i]
- req_last  in  N  byte is last of its frame; sampled with req_byte
- req_busy  out  N  per-requester busy, transmitter-style
- tx_busy  in  1  transmitter busy
- tx_byte  out  8  byte to transmitter, registered
- send  out  1  transmitter send strobe, registered
- owner  out  3  index of current owner, valid when locked=1
- locked  out  1  grant held; state is not IDLE

Behaviour:
- Reset (rst_n=0 at a clk_sys edge) has priority over everything, including mid-frame. Results:
  - state=IDLE, send=0, tx_byte=0, req_busy=0, owner=0, locked=0.
  - Round-robin pointer=0, timeout counter=0.
  - A byte already inside the transmitter is not recalled.
- States: IDLE, SEND, WAIT_TRANS, LOCK.
- IDLE transitions:
  - Scan req_send starting at the pointer, wrapping modulo N. The first set bit wins.
  - On a win: owner<=i, tx_byte<=byte i, last_r<=req_last[i], go to SEND.
  - No request: stay in IDLE.
  - Grant latency: 1 cycle from req_send sampled to state=SEND.
- SEND: send=1 and req_busy[owner]=1. Stay until tx_busy=1, then send<=0 and go to WAIT_TRANS. There is no timeout here.
- WAIT_TRANS: req_busy[owner]=1. When tx_busy=0:
  - If last_r=1: pointer<=(owner+1) mod N, go to IDLE.
  - Otherwise: clear the timeout counter and go to LOCK.
- LOCK: req_busy=0 for all requesters.
  - If req_send[owner]=1: latch byte and last, go to SEND.
  - Otherwise increment the timeout counter. When it reaches LOCK_TIMEOUT: pointer<=(owner+1) mod N, go to IDLE (frame abandoned).
  - Requests from non-owners are ignored in LOCK.
- req_busy[i] is 1 only when i=owner and state is SEND or WAIT_TRANS. Non-owners always see 0, so their pending send stays held and is never mistaken for acceptance.
- tx_byte is stable from entry to SEND until the next grant latch; it does not change during WAIT_TRANS.
- Simultaneous requests in IDLE: only the round-robin winner is granted. Losers stay pending with req_busy=0.
- Owner dropping req_send during SEND: the transfer still completes. Requesters must hold req_send until req_busy is seen.
- tx_busy already high on entry to SEND: go to WAIT_TRANS the next cycle. send is high for exactly 1 cycle.
- Pointer wrap: owner=N-1 gives pointer=0.
- Timeout counter width: clog2(LOCK_TIMEOUT+1). The counter saturates and never wraps.

Decomposition:
- Shared package cp_pkg holds:
  - state encoding localparams ST_IDLE=0, ST_SEND=1, ST_WAIT_TRANS=2, ST_LOCK=3;
  - default N and LOCK_TIMEOUT constants;
  - requester index assignments: CP_REQ_STATUS=0, CP_REQ_ECHO=1, CP_REQ_DEBUG=2.
- One sub-module, rr_pick: combinational round-robin picker.
  - Inputs: req[N], ptr.
  - Outputs: valid, idx.
  - Implemented with a doubled-vector priority scan.

Test Plan:
- Single frame, no contention: requester 0 sends 4 bytes 0x12,0x34,0x56,0x9A with last on the 4th; transmitter model busy 10 cycles per byte.
  - -> tx_byte sequence 12,34,56,9A; send pulses exactly 4.
  - -> owner=0 throughout; pointer=1 after; locked=0 at end.
- Contention: req_send=3'b111 in one cycle with pointer=0; each requester sends a 2-byte frame.
  - -> frames serviced in order 0,1,2, never interleaved.
  - -> req_busy[1] and req_busy[2] stay 0 while requester 0 owns.
- Round-robin wrap: pointer=2 and requesters 0 and 2 request -> 2 granted first, then 0; pointer ends at 1.
- Lock timeout: LOCK_TIMEOUT=15; requester 1 sends a non-last byte then goes silent; requester 0 is pending.
  - -> 15 cycles into LOCK the grant is released.
  - -> requester 0 granted on the next cycle; owner=0.
- Reset mid-frame: assert rst_n=0 for 1 cycle during WAIT_TRANS of byte 2 of a 4-byte frame.
  - -> next cycle: send=0, req_busy=0, locked=0, pointer=0.
  - -> a fresh request is granted normally afterwards.
- Immediate busy: transmitter raises tx_busy in the same cycle send rises.
  - -> send high for exactly 1 cycle.
  - -> req_busy[owner] high until tx_busy falls.

Source files
------------

// File: rtl/cp_tx_arb_pkg.sv
// Shared definitions for the control-panel transmit arbiter.
//   - FSM state encoding
//   - default requester count and lock timeout
//   - fixed requester index assignments
//   - beat struct (byte + last flag) and a modulo-N index increment helper
package cp_pkg;
  localparam int CP_N            = 3;
  localparam int CP_LOCK_TIMEOUT = 1023;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_SEND       = 2'd1;
  localparam logic [1:0] ST_WAIT_TRANS = 2'd2;
  localparam logic [1:0] ST_LOCK       = 2'd3;

  localparam int CP_REQ_STATUS = 0;
  localparam int CP_REQ_ECHO   = 1;
  localparam int CP_REQ_DEBUG  = 2;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } cp_beat_t;

  // (i + 1) mod n for requester indices
  function automatic logic [2:0] cp_next_idx(input logic [2:0] i, input int n);
    return (int'(i) >= n - 1) ? 3'd0 : i + 3'd1;
  endfunction
endpackage

// File: rtl/cp_tx_arb_if.sv
// Bundle of requester-side and transmitter-side signals of the arbiter.
//   req_send/req_byte/req_last : per-requester send strobe, byte, last flag
//   req_busy                   : per-requester busy back to the sources
//   tx_busy/tx_byte/send       : transmitter handshake
// master = arbiter side, slave = sources + transmitter side.
interface cp_tx_arb_if
  import cp_pkg::*;
#(
  parameter int N = CP_N
) ();
  logic [N-1:0]       req_send;
  logic [N-1:0][7:0]  req_byte;
  logic [N-1:0]       req_last;
  logic [N-1:0]       req_busy;
  logic               tx_busy;
  logic [7:0]         tx_byte;
  logic               send;

  modport master (input  req_send, req_byte, req_last, tx_busy,
                  output req_busy, tx_byte, send);
  modport slave  (output req_send, req_byte, req_last, tx_busy,
                  input  req_busy, tx_byte, send);
endinterface

// File: rtl/cp_tx_arb_rr_pick.sv
// Combinational round-robin picker.
//   req   : request vector
//   ptr   : index with highest priority this scan
//   valid : some request is set
//   idx   : first set request at or after ptr, wrapping modulo N
// The request vector is doubled so the wrapped scan becomes a plain
// window [ptr, ptr+N) over a 2N-bit vector.
module rr_pick #(
  parameter int N = 3
) (
  input  logic [N-1:0] req,
  input  logic [2:0]   ptr,
  output logic         valid,
  output logic [2:0]   idx
);
  logic [2*N-1:0] req2;
  assign req2 = {req, req};

  // descending scan: the lowest position inside the window is written last
  always_comb begin
    valid = 1'b0;
    idx   = 3'd0;
    for (int j = 2*N-1; j >= 0; j--) begin
      if (req2[j] && (j >= int'(ptr)) && (j < int'(ptr) + N)) begin
        valid = 1'b1;
        idx   = (j >= N) ? 3'(j - N) : 3'(j);
      end
    end
  end
endmodule

// File: rtl/cp_tx_arb.sv
// Shares one serial transmitter between N byte-stream sources.
//   clk_sys, rst_n : clock, synchronous active-low reset
//   bus            : requester send/busy handshakes and transmitter handshake
//   owner          : current grant owner (valid while locked)
//   locked         : a frame is in progress (FSM not idle)
// Grant is held across a frame until the owner's last byte; round-robin
// pointer advances only at frame end or lock timeout.
module cp_tx_arb
  import cp_pkg::*;
#(
  parameter int N            = CP_N,
  parameter int LOCK_TIMEOUT = CP_LOCK_TIMEOUT
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  cp_tx_arb_if.master bus,
  output logic [2:0]  owner,
  output logic        locked
);
  localparam int CW = $clog2(LOCK_TIMEOUT + 1);

  logic [1:0]    state, state_nx;
  logic [2:0]    ptr;
  logic [CW-1:0] to_cnt;
  logic [7:0]    byte_r;
  logic          last_r;
  logic          send_r;
  logic          pick_vld;
  logic [2:0]    pick_idx;
  logic          own_send;
  cp_beat_t      own_beat, pick_beat;
  logic          to_hit;

  rr_pick #(.N(N)) u_pick (
    .req   (bus.req_send),
    .ptr   (ptr),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  // select owner's and winner's request lanes
  always_comb begin
    own_send  = 1'b0;
    own_beat  = '0;
    pick_beat = '0;
    for (int i = 0; i < N; i++) begin
      if (owner == 3'(i)) begin
        own_send      = bus.req_send[i];
        own_beat.data = bus.req_byte[i];
        own_beat.last = bus.req_last[i];
      end
      if (pick_idx == 3'(i)) begin
        pick_beat.data = bus.req_byte[i];
        pick_beat.last = bus.req_last[i];
      end
    end
  end

  // the silent cycle that brings the counter to LOCK_TIMEOUT releases the lock
  assign to_hit = (int'(to_cnt) + 1 >= LOCK_TIMEOUT);

  // state register + grant datapath
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      owner  <= 3'd0;
      ptr    <= 3'd0;
      to_cnt <= '0;
      byte_r <= 8'd0;
      last_r <= 1'b0;
      send_r <= 1'b0;
    end else begin
      state  <= state_nx;
      send_r <= (state_nx == ST_SEND);
      case (state)
        ST_IDLE: if (pick_vld) begin
          owner  <= pick_idx;
          byte_r <= pick_beat.data;
          last_r <= pick_beat.last;
        end
        ST_WAIT_TRANS: if (!bus.tx_busy) begin
          if (last_r) ptr    <= cp_next_idx(owner, N);
          else        to_cnt <= '0;
        end
        ST_LOCK: if (own_send) begin
          byte_r <= own_beat.data;
          last_r <= own_beat.last;
        end else begin
          if (to_cnt != CW'(LOCK_TIMEOUT)) to_cnt <= to_cnt + 1'b1;
          if (to_hit) ptr <= cp_next_idx(owner, N);
        end
        default: ;
      endcase
    end
  end

  // next state
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:       if (pick_vld) state_nx = ST_SEND;
      ST_SEND:       if (bus.tx_busy) state_nx = ST_WAIT_TRANS;
      ST_WAIT_TRANS: if (!bus.tx_busy) state_nx = last_r ? ST_IDLE : ST_LOCK;
      ST_LOCK: begin
        if (own_send)    state_nx = ST_SEND;
        else if (to_hit) state_nx = ST_IDLE;
      end
      default:       state_nx = ST_IDLE;
    endcase
  end

  // outputs: only the owner sees busy, and only while its byte is in flight
  always_comb begin
    bus.req_busy = '0;
    if (state == ST_SEND || state == ST_WAIT_TRANS) begin
      for (int i = 0; i < N; i++)
        if (owner == 3'(i)) bus.req_busy[i] = 1'b1;
    end
  end

  assign locked      = (state != ST_IDLE);
  assign bus.send    = send_r;
  assign bus.tx_byte = byte_r;
endmodule

// File: tb/tb_cp_tx_arb.sv
module tb_cp_tx_arb;
  import cp_pkg::*;
  localparam int N  = 3;
  localparam int LT = 15;

  logic       clk_sys = 1'b0;
  logic       rst_n   = 1'b0;
  logic [2:0] owner;
  logic       locked;

  cp_tx_arb_if #(.N(N)) bus ();

  cp_tx_arb #(.N(N), .LOCK_TIMEOUT(LT)) dut (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .bus     (bus),
    .owner   (owner),
    .locked  (locked)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm, input int n);
    checks++;
    errors++;
    $display("FAIL %s: no progress after %0d cycles, required completion", nm, n);
  endtask

  // source byte queues {last, byte} and expected transmit order {owner, byte}
  logic [8:0]  src_q [N][$];
  logic [10:0] exp_q [$];

  task automatic add_src(input int s, input logic [7:0] b, input logic last);
    src_q[s].push_back({last, b});
  endtask
  task automatic add_exp(input int s, input logic [7:0] b);
    exp_q.push_back({3'(s), b});
  endtask

  // requester drivers: transmitter-style senders
  initial begin
    bus.req_send = '0;
    bus.req_byte = '0;
    bus.req_last = '0;
    forever begin
      @(negedge clk_sys);
      for (int i = 0; i < N; i++) begin
        if (bus.req_send[i]) begin
          if (bus.req_busy[i]) begin
            bus.req_send[i] = 1'b0;
            if (src_q[i].size() > 0) src_q[i].delete(0);
          end
        end else if (!bus.req_busy[i] && src_q[i].size() > 0) begin
          bus.req_send[i] = 1'b1;
          bus.req_byte[i] = src_q[i][0][7:0];
          bus.req_last[i] = src_q[i][0][8];
        end
      end
    end
  end

  // transmitter: accepts send after tx_dly cycles, then busy for tx_len cycles
  int tx_dly = 0, tx_len = 3;
  initial begin
    int busy_left = 0;
    int wait_n    = 0;
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (busy_left > 0) begin
        busy_left--;
        bus.tx_busy = (busy_left > 0);
      end else if (bus.send) begin
        if (wait_n >= tx_dly) begin
          wait_n      = 0;
          busy_left   = tx_len;
          bus.tx_busy = 1'b1;
        end else wait_n++;
      end
    end
  end

  // model: every grant delivers the next expected {owner, byte}; the owner is
  // busy from grant until the transmitter has been seen busy and idle again
  int         send_rises = 0, send_hi = 0;
  logic [2:0] own_m  = 3'd0;
  logic [7:0] byte_m = 8'd0;
  logic       inf = 1'b0, seen = 1'b0, sp = 1'b0;
  initial begin
    forever begin
      @(posedge clk_sys); #1;
      if (!rst_n) begin
        check("rst_send", 32'(bus.send), 0);
        check("rst_req_busy", 32'(bus.req_busy), 0);
        check("rst_locked", 32'(locked), 0);
        check("rst_owner", 32'(owner), 0);
        check("rst_tx_byte", 32'(bus.tx_byte), 0);
        inf = 0; seen = 0; sp = 0; byte_m = 0; own_m = 0;
      end else begin
        if (bus.send && !sp) begin
          send_rises++;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_send: got byte %0h owner %0d, required no send", bus.tx_byte, owner);
          end else begin
            own_m  = exp_q[0][10:8];
            byte_m = exp_q[0][7:0];
            exp_q.delete(0);
          end
          inf = 1; seen = 0;
        end else if (inf) begin
          if (!seen && bus.tx_busy)      seen = 1;
          else if (seen && !bus.tx_busy) inf  = 0;
        end
        if (bus.send) send_hi++;
        check("send", 32'(bus.send), 32'(inf && !seen));
        check("req_busy", 32'(bus.req_busy), inf ? (32'd1 << own_m) : 32'd0);
        check("tx_byte", 32'(bus.tx_byte), 32'(byte_m));
        if (inf) begin
          check("owner", 32'(owner), 32'(own_m));
          check("locked", 32'(locked), 1);
        end
        sp = bus.send;
      end
    end
  end

  function automatic bit src_empty();
    for (int i = 0; i < N; i++) if (src_q[i].size() != 0) return 0;
    return 1;
  endfunction

  task automatic tick();
    @(posedge clk_sys); #2;
  endtask

  task automatic wait_quiet(input string nm);
    int n = 0;
    while (n < 3000 && !(src_empty() && bus.req_send == '0 && !locked &&
                         !bus.tx_busy && exp_q.size() == 0)) begin
      tick(); n++;
    end
    if (n >= 3000) fail_now(nm, n);
    tick();
  endtask

  initial begin
    int r0, h0, n;
    repeat (3) tick();
    @(negedge clk_sys); rst_n = 1'b1;
    tick();
    check("post_rst_locked", 32'(locked), 0);

    // contention: all three request together, pointer 0 -> order 0,1,2
    tx_dly = 0; tx_len = 3;
    add_src(CP_REQ_STATUS, 8'hA0, 0); add_src(CP_REQ_STATUS, 8'hA1, 1);
    add_src(CP_REQ_ECHO,   8'hB0, 0); add_src(CP_REQ_ECHO,   8'hB1, 1);
    add_src(CP_REQ_DEBUG,  8'hC0, 0); add_src(CP_REQ_DEBUG,  8'hC1, 1);
    add_exp(0, 8'hA0); add_exp(0, 8'hA1);
    add_exp(1, 8'hB0); add_exp(1, 8'hB1);
    add_exp(2, 8'hC0); add_exp(2, 8'hC1);
    n = 0;
    while (bus.req_send != 3'b111 && n < 20) begin tick(); n++; end
    check("contend_all_req", 32'(bus.req_send), 32'b111);
    check("contend_first_owner", 32'(owner), 0);
    wait_quiet("contention");

    // single 4-byte frame, send held 3 cycles per byte, busy 10 cycles
    tx_dly = 2; tx_len = 10;
    r0 = send_rises; h0 = send_hi;
    add_src(0, 8'h12, 0); add_src(0, 8'h34, 0); add_src(0, 8'h56, 0); add_src(0, 8'h9A, 1);
    add_exp(0, 8'h12); add_exp(0, 8'h34); add_exp(0, 8'h56); add_exp(0, 8'h9A);
    wait_quiet("single_frame");
    check("single_send_pulses", 32'(send_rises - r0), 4);
    check("single_send_hi_cycles", 32'(send_hi - h0), 12);
    check("single_locked_end", 32'(locked), 0);

    // pointer now 1: requesters 0 and 1 contend -> 1 first, then 0
    tx_dly = 0; tx_len = 3;
    add_src(0, 8'h01, 1); add_src(1, 8'h11, 1);
    add_exp(1, 8'h11); add_exp(0, 8'h01);
    wait_quiet("ptr1_probe");

    // requester 1 alone -> pointer 2
    add_src(1, 8'h22, 1); add_exp(1, 8'h22);
    wait_quiet("ptr2_setup");

    // wrap: pointer 2, requesters 0 and 2 -> 2 then 0, pointer ends 1
    add_src(0, 8'h30, 1); add_src(2, 8'h32, 1);
    add_exp(2, 8'h32); add_exp(0, 8'h30);
    wait_quiet("rr_wrap");

    // lock timeout: pointer 1 so requester 1 wins, sends non-last then silent
    add_src(1, 8'h77, 0); add_src(0, 8'h41, 1);
    add_exp(1, 8'h77); add_exp(0, 8'h41);
    n = 0;
    while (!(locked && bus.req_busy == '0 && !bus.send) && n < 200) begin tick(); n++; end
    if (n >= 200) fail_now("lock_entry", n);
    check("lock_owner", 32'(owner), 1);
    check("lock_pending_req0", 32'(bus.req_send[0]), 1);
    n = 0;
    while (locked && bus.req_busy == '0 && n < 100) begin tick(); n++; end
    check("lock_cycles", 32'(n), LT);
    check("lock_released", 32'(locked), 0);
    tick();
    check("after_to_send", 32'(bus.send), 1);
    check("after_to_owner", 32'(owner), 0);
    wait_quiet("timeout");

    // reset during WAIT_TRANS of byte 2 of a 4-byte frame
    tx_len = 6;
    add_src(2, 8'hD0, 0); add_src(2, 8'hD1, 0); add_src(2, 8'hD2, 0); add_src(2, 8'hD3, 1);
    add_exp(2, 8'hD0); add_exp(2, 8'hD1);
    n = 0;
    while (!(exp_q.size() == 0 && !bus.send && bus.req_busy[2]) && n < 300) begin tick(); n++; end
    if (n >= 300) fail_now("reset_setup", n);
    @(negedge clk_sys); rst_n = 1'b0; src_q[2].delete();
    @(negedge clk_sys); rst_n = 1'b1;
    #1;
    check("midrst_send", 32'(bus.send), 0);
    check("midrst_req_busy", 32'(bus.req_busy), 0);
    check("midrst_locked", 32'(locked), 0);
    wait_quiet("reset_drain");
    // pointer reset to 0: requesters 0 and 2 -> 0 first
    tx_len = 3;
    add_src(0, 8'hE0, 1); add_src(2, 8'hE2, 1);
    add_exp(0, 8'hE0); add_exp(2, 8'hE2);
    wait_quiet("post_reset");

    // immediate busy: grant latency 1, send 1 cycle, busy tx_len+1 cycles
    tx_dly = 0; tx_len = 4;
    h0 = send_hi;
    add_src(1, 8'h5A, 1); add_exp(1, 8'h5A);
    n = 0;
    while (!bus.req_send[1] && n < 20) begin tick(); n++; end
    check("grant_latency_send", 32'(bus.send), 1);
    check("grant_latency_owner", 32'(owner), 1);
    n = 0;
    while (bus.req_busy[1] && n < 50) begin tick(); n++; end
    check("imm_busy_cycles", 32'(n), 5);
    check("imm_send_hi_cycles", 32'(send_hi - h0), 1);
    wait_quiet("immediate");
    check("exp_drained", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end
endmodule
